// File: rtl/gate_chk_pkg.sv
// ============================================================================
// Module   : gate_chk_pkg
// Brief    : Shared types and truth-table constants for 2-input gate checkers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gate_chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int VEC_W   = 2;
    localparam int NUM_VEC = 4;

    // Truth tables indexed by {a,b}: bit i is the expected output for vector i.
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

`default_nettype wire

// File: rtl/settle_timer.sv
// ============================================================================
// Module   : settle_timer
// Brief    : 8-bit load / count-down counter with a zero flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 8'd0)) begin
            count <= count - 8'd1;
        end
    end

    assign zero = (count == 8'd0);

endmodule

`default_nettype wire

// File: rtl/gate_tt_checker.sv
// ============================================================================
// Module   : gate_tt_checker
// Brief    : Drives all four vectors onto a 2-input gate and checks its output
//            against a truth table, reporting pass, error count, first failure.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_tt_checker
    import gate_chk_pkg::*;
#(
    parameter logic [3:0] TT            = TT_NAND,
    parameter int         SETTLE_CYCLES = 2,
    parameter int         ERR_W         = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             dut_y,
    output logic             a_out,
    output logic             b_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [1:0]       fail_idx
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t             state;
    logic [VEC_W-1:0]   idx;
    logic               tmr_zero;
    logic               mismatch;
    logic [ERR_W-1:0]   err_next;

    settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == ST_DRIVE),
        .load_val (SETTLE_LOAD),
        .dec      (state == ST_SETTLE),
        .zero     (tmr_zero)
    );

    // Case-inequality so an X/Z from the gate model is flagged, not masked.
    assign mismatch = (dut_y !== TT[idx]);
    assign err_next = (mismatch && !(&err_count)) ? err_count + ERR_W'(1) : err_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            a_out      <= 1'b0;
            b_out      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_idx   <= 2'b00;
        end else begin
            done <= 1'b0;
            if ((state != ST_IDLE) && abort) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                pass  <= 1'b0;
                a_out <= 1'b0;
                b_out <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state      <= ST_DRIVE;
                            busy       <= 1'b1;
                            idx        <= '0;
                            a_out      <= 1'b0;
                            b_out      <= 1'b0;
                            err_count  <= '0;
                            fail_valid <= 1'b0;
                            fail_idx   <= 2'b00;
                            pass       <= 1'b0;
                        end
                    end
                    ST_DRIVE: begin
                        state <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (tmr_zero) begin
                            state <= ST_SAMPLE;
                        end
                    end
                    ST_SAMPLE: begin
                        err_count <= err_next;
                        if (mismatch && !fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_idx   <= idx;
                        end
                        if (idx == 2'd3) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == '0);
                        end else begin
                            state          <= ST_DRIVE;
                            idx            <= idx + 2'd1;
                            {a_out, b_out} <= idx + 2'd1;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gate_tt_checker.sv
// ============================================================================
// Module   : tb_gate_tt_checker
// Brief    : Directed self-checking bench for gate_tt_checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_tt_checker;

    localparam int GOOD_NAND = 0;
    localparam int STUCK1    = 1;
    localparam int NOR_GATE  = 2;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, start1;
    logic       dut_y;
    logic       dut_y1;
    int         mode;

    logic       a_out, b_out, busy, done, pass, fail_valid;
    logic [2:0] err_count;
    logic [1:0] fail_idx;

    logic       a1, b1, busy1, done1, pass1, fv1;
    logic [0:0] err1;
    logic [1:0] fidx1;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    always_comb begin
        case (mode)
            GOOD_NAND: dut_y = ~(a_out & b_out);
            STUCK1:    dut_y = 1'b1;
            NOR_GATE:  dut_y = ~(a_out | b_out);
            default:   dut_y = 1'b0;
        endcase
    end

    assign dut_y1 = 1'b0;

    gate_tt_checker u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_y(dut_y),
        .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_valid(fail_valid), .fail_idx(fail_idx)
    );

    gate_tt_checker #(.ERR_W(1)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .dut_y(dut_y1),
        .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_valid(fv1), .fail_idx(fidx1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_results(input string tag, input logic [2:0] e_err,
                               input logic [1:0] e_fidx, input logic e_fv,
                               input logic e_pass);
        chk({tag, " err_count"},  8'(err_count),  8'(e_err));
        chk({tag, " fail_idx"},   8'(fail_idx),   8'(e_fidx));
        chk({tag, " fail_valid"}, 8'(fail_valid), 8'(e_fv));
        chk({tag, " pass"},       8'(pass),       8'(e_pass));
    endtask

    // One full run: vector sequence, busy and done timing, then final results.
    task automatic run(input string tag, input logic [2:0] e_err, input logic [1:0] e_fidx,
                       input logic e_fv, input logic e_pass,
                       input logic repulse, input logic with_abort);
        start = 1'b1;
        abort = with_abort;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        for (int c = 0; c <= 16; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            chk({tag, " ab"},   8'({a_out, b_out}), (c < 16) ? 8'(c / 4) : 8'd3);
            chk({tag, " busy"}, 8'(busy), 8'(c < 16));
            chk({tag, " done"}, 8'(done), 8'(c == 16));
            if (repulse) start = (c == 6);
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk({tag, " done_end"}, 8'(done), 8'd0);
        chk_results(tag, e_err, e_fidx, e_fv, e_pass);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        start1 = 1'b0;
        mode   = GOOD_NAND;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ab",   8'({a_out, b_out}), 8'd0);
        chk("reset busy", 8'(busy), 8'd0);
        chk("reset done", 8'(done), 8'd0);
        chk_results("reset", 3'd0, 2'd0, 1'b0, 1'b0);
        chk("reset sat err", 8'(err1), 8'd0);
        rst_n = 1'b1;

        // ERR_W=1 instance, stuck-at-0 GUT: mismatches at 00,01,10 saturate at 1.
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        chk("sat done", 8'(done1), 8'd1);
        @(posedge clk); #1;
        chk("sat err",  8'(err1),  8'd1);
        chk("sat fidx", 8'(fidx1), 8'd0);
        chk("sat fv",   8'(fv1),   8'd1);
        chk("sat pass", 8'(pass1), 8'd0);

        mode = GOOD_NAND;
        run("good", 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk_results("idle_abort", 3'd0, 2'd0, 1'b0, 1'b1);

        mode = STUCK1;
        run("stuck1", 3'd1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);

        // NOR vs NAND differ only at 01 and 10; start also wins over abort here.
        mode = NOR_GATE;
        run("nor", 3'd2, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1);

        // Abort during SETTLE of vector 2, after the mismatch at 01 is recorded.
        mode  = NOR_GATE;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("abort pre ab",   8'({a_out, b_out}), 8'd2);
        chk("abort pre busy", 8'(busy), 8'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort ab",   8'({a_out, b_out}), 8'd0);
        chk("abort busy", 8'(busy), 8'd0);
        chk("abort done", 8'(done), 8'd0);
        chk_results("abort", 3'd1, 2'd1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("abort no_done", 8'({done, busy}), 8'd0);
        end
        mode = GOOD_NAND;
        run("after_abort", 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset mid-run clears everything.
        mode  = NOR_GATE;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midrun err", 8'(err_count), 8'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst ab",   8'({a_out, b_out}), 8'd0);
        chk("midrst busy", 8'(busy), 8'd0);
        chk("midrst done", 8'(done), 8'd0);
        chk_results("midrst", 3'd0, 2'd0, 1'b0, 1'b0);

        mode = GOOD_NAND;
        run("repulse", 3'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
